// File: rtl/dmem_arbiter_if.sv
// Memory access type package and the per-requester request/response bundle
// used between a requester (master) and the data-memory arbiter (slave).
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    MEM_DISABLED = 2'd0,
    MEM_READ     = 2'd1,
    MEM_WRITE    = 2'd2
  } memaccess_t;
endpackage

interface dmem_arbiter_if;
  logic        valid;
  logic        ready;
  logic        write;
  logic [29:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output valid, write, addr, wstrb, wdata,
    input  ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  valid, write, addr, wstrb, wdata,
    output ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core (p0) first with a
// DMA (p1) starvation guard; define DMEM_ARB_RR_EN to use round-robin instead.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output memaccess_t        memaccess_o,
  output logic [29:0]       word_addr_o,
  output logic [3:0]        wstrb_o,
  output logic [31:0]       wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_fault_i
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic       gnt0, gnt1;
  logic       inflight_q, inflight_d;
  logic       inflight_id_q, inflight_id_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
`ifdef DMEM_ARB_RR_EN
  logic       rr_last_q, rr_last_d;
`endif

  // Grants are forced low during reset so nothing reaches the memory.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
`ifdef DMEM_ARB_RR_EN
      gnt1 = p1.valid && (!p0.valid || !rr_last_q);
`else
      gnt1 = p1.valid && (!p0.valid || (wait_cnt_q == MaxWait));
`endif
      gnt0 = p0.valid && !gnt1;
    end
  end

  assign p0.ready = gnt0;
  assign p1.ready = gnt1;

  always_comb begin
    memaccess_o = MEM_DISABLED;
    word_addr_o = '0;
    wstrb_o     = '0;
    wdata_o     = '0;
    if (gnt1) begin
      memaccess_o = p1.write ? MEM_WRITE : MEM_READ;
      word_addr_o = p1.addr;
      wstrb_o     = p1.wstrb;
      wdata_o     = p1.wdata;
    end else if (gnt0) begin
      memaccess_o = p0.write ? MEM_WRITE : MEM_READ;
      word_addr_o = p0.addr;
      wstrb_o     = p0.wstrb;
      wdata_o     = p0.wdata;
    end
  end

  always_comb begin
    inflight_d    = gnt0 || gnt1;
    inflight_id_d = (gnt0 || gnt1) ? gnt1 : inflight_id_q;
`ifdef DMEM_ARB_RR_EN
    wait_cnt_d    = '0;
    rr_last_d     = (gnt0 || gnt1) ? gnt1 : rr_last_q;
`else
    if (gnt1 || !p1.valid) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      inflight_id_q <= 1'b0;
      wait_cnt_q    <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_last_q     <= 1'b1;
`endif
    end else begin
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      wait_cnt_q    <= wait_cnt_d;
`ifdef DMEM_ARB_RR_EN
      rr_last_q     <= rr_last_d;
`endif
    end
  end

  // Memory returns registered data, so the response is steered straight through.
  always_comb begin
    p0.rsp_valid = inflight_q && !inflight_id_q;
    p0.rsp_rdata = p0.rsp_valid ? mem_rdata_i : '0;
    p0.rsp_fault = p0.rsp_valid && mem_fault_i;
    p1.rsp_valid = inflight_q && inflight_id_q;
    p1.rsp_rdata = p1.rsp_valid ? mem_rdata_i : '0;
    p1.rsp_fault = p1.rsp_valid && mem_fault_i;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic
// against a queue-free reference model of grants, memory contents and responses.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MAXW  = 3;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if p0_bus ();
  dmem_arbiter_if p1_bus ();

  memaccess_t  memaccess;
  logic [29:0] word_addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic        mem_fault;
  logic        mem_init;

  dmem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk         (clk),
    .rst         (rst),
    .p0          (p0_bus),
    .p1          (p1_bus),
    .memaccess_o (memaccess),
    .word_addr_o (word_addr),
    .wstrb_o     (wstrb),
    .wdata_o     (wdata),
    .mem_rdata_i (mem_rdata),
    .mem_fault_i (mem_fault)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pat(int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Behavioural single-port memory: registered read of the pre-write word.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (memaccess != MEM_DISABLED) begin
      if (word_addr < 30'(DEPTH)) begin
        mem_rdata <= mem[word_addr[5:0]];
        mem_fault <= 1'b0;
        if (memaccess == MEM_WRITE)
          mem[word_addr[5:0]] <= merge(mem[word_addr[5:0]], wdata, wstrb);
      end else begin
        mem_rdata <= 32'h0;
        mem_fault <= 1'b1;
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          pend;
  int          pid;
  logic [31:0] prd;
  logic        pflt;
  int          mwait;
  int          mrr;
  int          last_gnt;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int p, logic v, logic wr, logic [29:0] a, logic [3:0] s, logic [31:0] d);
    if (p == 0) begin
      p0_bus.valid = v; p0_bus.write = wr; p0_bus.addr = a; p0_bus.wstrb = s; p0_bus.wdata = d;
    end else begin
      p1_bus.valid = v; p1_bus.write = wr; p1_bus.addr = a; p1_bus.wstrb = s; p1_bus.wdata = d;
    end
  endtask

  // One clock cycle: predict, compare combinational/response outputs, advance model.
  task automatic step();
    int          w;
    logic        v0, v1, ew;
    logic [29:0] ea;
    logic [3:0]  es;
    logic [31:0] ed;
    #1;
    v0 = p0_bus.valid;
    v1 = p1_bus.valid;
    w  = -1;
    if (rst) begin
      pend = 0; mwait = 0; mrr = 1;
    end else begin
`ifdef DMEM_ARB_RR_EN
      if (v0 && v1) w = (mrr == 1) ? 0 : 1;
      else if (v1)  w = 1;
      else if (v0)  w = 0;
`else
      if (v1 && (!v0 || mwait == MAXW)) w = 1;
      else if (v0)                      w = 0;
`endif
    end
    ew = 1'b0; ea = '0; es = '0; ed = '0;
    if (w == 0) begin ew = p0_bus.write; ea = p0_bus.addr; es = p0_bus.wstrb; ed = p0_bus.wdata; end
    if (w == 1) begin ew = p1_bus.write; ea = p1_bus.addr; es = p1_bus.wstrb; ed = p1_bus.wdata; end

    chk("p0_ready", 64'(p0_bus.ready), 64'(w == 0));
    chk("p1_ready", 64'(p1_bus.ready), 64'(w == 1));
    chk("memaccess", 64'(memaccess),
        64'((w < 0) ? MEM_DISABLED : (ew ? MEM_WRITE : MEM_READ)));
    chk("word_addr", 64'(word_addr), 64'(ea));
    chk("wstrb", 64'(wstrb), 64'(es));
    chk("wdata", 64'(wdata), 64'(ed));
    chk("p0_rsp_valid", 64'(p0_bus.rsp_valid), 64'(pend && pid == 0));
    chk("p0_rsp_rdata", 64'(p0_bus.rsp_rdata), 64'((pend && pid == 0) ? prd : 32'h0));
    chk("p0_rsp_fault", 64'(p0_bus.rsp_fault), 64'(pend && pid == 0 && pflt));
    chk("p1_rsp_valid", 64'(p1_bus.rsp_valid), 64'(pend && pid == 1));
    chk("p1_rsp_rdata", 64'(p1_bus.rsp_rdata), 64'((pend && pid == 1) ? prd : 32'h0));
    chk("p1_rsp_fault", 64'(p1_bus.rsp_fault), 64'(pend && pid == 1 && pflt));
    last_gnt = p1_bus.ready ? 1 : (p0_bus.ready ? 0 : -1);

    @(posedge clk);
    if (!rst) begin
      pend = (w >= 0);
      if (w >= 0) begin
        pid = w;
        if (ea < 30'(DEPTH)) begin
          prd  = ref_mem[ea[5:0]];
          pflt = 1'b0;
          if (ew) ref_mem[ea[5:0]] = merge(ref_mem[ea[5:0]], ed, es);
        end else begin
          prd  = 32'h0;
          pflt = 1'b1;
        end
        mrr = w;
      end
      if (v1 && w == 0)       mwait = (mwait < MAXW) ? mwait + 1 : MAXW;
      else if (w == 1 || !v1) mwait = 0;
    end
    @(negedge clk);
  endtask

  int grants [8];
  int exp_g  [8];

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    pend = 0; pid = 0; prd = '0; pflt = 0; mwait = 0; mrr = 1; last_gnt = -1;
    @(negedge clk);
    mem_init = 1'b0;

    // Reset: requests are ignored and nothing reaches the memory
    set_req(0, 1, 1, 30'h3, 4'hF, 32'h1234_5678);
    step();
    set_req(0, 0, 0, '0, '0, '0);
    rst = 1'b0;
    step();

    // Single request: write then read back
    set_req(0, 1, 1, 30'h10, 4'hF, 32'hDEAD_BEEF);
    step();
    set_req(0, 1, 0, 30'h10, 4'h0, 32'h0);
    step();
    set_req(0, 0, 0, '0, '0, '0);
    chk("t1_p0_rsp_valid", 64'(p0_bus.rsp_valid), 64'd1);
    chk("t1_p0_rdata", 64'(p0_bus.rsp_rdata), 64'hDEAD_BEEF);
    chk("t1_p1_rsp_valid", 64'(p1_bus.rsp_valid), 64'd0);
    step();

    // Byte strobe merge on port 1
    set_req(1, 1, 1, 30'h20, 4'hF, 32'h1122_3344);
    step();
    set_req(1, 1, 1, 30'h20, 4'b0001, 32'h0000_00AA);
    step();
    set_req(1, 1, 0, 30'h20, 4'h0, 32'h0);
    step();
    set_req(1, 0, 0, '0, '0, '0);
    chk("t2_p1_rdata", 64'(p1_bus.rsp_rdata), 64'h1122_33AA);
    step();

    // Contention from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1, 0, 30'h1, 4'h0, 32'h0);
    set_req(1, 1, 0, 30'h2, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      grants[i] = last_gnt;
`ifdef DMEM_ARB_RR_EN
      exp_g[i] = i % 2;
`else
      exp_g[i] = ((i % (MAXW + 1)) == MAXW) ? 1 : 0;
`endif
    end
    for (int i = 0; i < 8; i++) chk($sformatf("t3_grant%0d", i), 64'(grants[i]), 64'(exp_g[i]));
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    step();

    // Fault routing: out-of-range p1 read, then a good p0 read alongside its response
    set_req(1, 1, 0, 30'd100, 4'h0, 32'h0);
    step();
    set_req(1, 0, 0, '0, '0, '0);
    chk("t4_p1_rsp_valid", 64'(p1_bus.rsp_valid), 64'd1);
    chk("t4_p1_rsp_fault", 64'(p1_bus.rsp_fault), 64'd1);
    chk("t4_p1_rdata", 64'(p1_bus.rsp_rdata), 64'd0);
    set_req(0, 1, 0, 30'h5, 4'h0, 32'h0);
    step();
    set_req(0, 0, 0, '0, '0, '0);
    chk("t4_p0_rsp_valid", 64'(p0_bus.rsp_valid), 64'd1);
    chk("t4_p0_rsp_fault", 64'(p0_bus.rsp_fault), 64'd0);
    chk("t4_p0_rdata", 64'(p0_bus.rsp_rdata), 64'(pat(5)));
    step();

    // Reset right after an accept drops the response
    set_req(0, 1, 0, 30'h7, 4'h0, 32'h0);
    step();
    rst = 1'b1;
    #1;
    chk("t5_p0_rsp_in_rst", 64'(p0_bus.rsp_valid), 64'd0);
    chk("t5_memaccess_in_rst", 64'(memaccess), 64'(MEM_DISABLED));
    step();
    set_req(0, 0, 0, '0, '0, '0);
    rst = 1'b0;
    step();
    chk("t5_p0_rsp_after_rst", 64'(p0_bus.rsp_valid), 64'd0);

    // Random traffic, fields free to change while stalled
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++)
        set_req(p, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                30'($urandom_range(0, DEPTH + 7)), 4'($urandom_range(0, 15)), $urandom);
      step();
    end
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
